// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch (IF) and
// data memory (DM) with a request/ack FSM, pipeline stall and access watchdog.
// Optional: define MEM_ARB_RR_EN for round-robin arbitration (default: DM priority).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              err_o,
  output logic [1:0]        grant_o
);

  localparam int unsigned TMR_W = 8;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d, timer_inc_c;
  logic               mem_req_d, mem_we_d, if_ack_d, dm_ack_d, err_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_d, if_rdata_d, dm_rdata_d;
  logic [1:0]         grant_d;
  logic               pick_dm_c;

  // Arbitration winner when the FSM is idle and at least one port requests
`ifdef MEM_ARB_RR_EN
  logic last_dm_q, last_dm_d;
  assign pick_dm_c = dm_req_i & (~if_req_i | ~last_dm_q);
`else
  assign pick_dm_c = dm_req_i;
`endif

  assign timer_inc_c = timer_q + TMR_W'(1);
  assign stall_o     = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    mem_req_d   = mem_req_o;
    mem_we_d    = mem_we_o;
    mem_addr_d  = mem_addr_o;
    mem_wdata_d = mem_wdata_o;
    if_rdata_d  = if_rdata_o;
    dm_rdata_d  = dm_rdata_o;
    grant_d     = grant_o;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    err_d       = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_dm_d   = last_dm_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (if_req_i | dm_req_i) begin
          grant_d     = pick_dm_c ? 2'b10 : 2'b01;
          mem_req_d   = 1'b1;
          mem_we_d    = pick_dm_c & dm_we_i;
          mem_addr_d  = pick_dm_c ? dm_addr_i : if_addr_i;
          mem_wdata_d = pick_dm_c ? dm_wdata_i : '0;
          timer_d     = '0;
          state_d     = BUSY;
`ifdef MEM_ARB_RR_EN
          last_dm_d   = pick_dm_c;
`endif
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (grant_o[1]) begin
            if (!mem_we_o) dm_rdata_d = mem_rdata_i;
            dm_ack_d = dm_req_i;
          end else begin
            if_rdata_d = mem_rdata_i;
            if_ack_d   = if_req_i;
          end
        end else if (timer_q == TMR_MAX) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = RESP;
          if (grant_o[1]) begin
            dm_rdata_d = '0;
            dm_ack_d   = dm_req_i;
          end else begin
            if_rdata_d = '0;
            if_ack_d   = if_req_i;
          end
        end else begin
          // Request drops as the timer reaches the limit; a late ack is still taken
          timer_d = timer_inc_c;
          if (timer_inc_c == TMR_MAX) mem_req_d = 1'b0;
        end
      end
      RESP: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
      if_ack_o    <= 1'b0;
      dm_ack_o    <= 1'b0;
      err_o       <= 1'b0;
      grant_o     <= '0;
`ifdef MEM_ARB_RR_EN
      last_dm_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      mem_req_o   <= mem_req_d;
      mem_we_o    <= mem_we_d;
      mem_addr_o  <= mem_addr_d;
      mem_wdata_o <= mem_wdata_d;
      if_rdata_o  <= if_rdata_d;
      dm_rdata_o  <= dm_rdata_d;
      if_ack_o    <= if_ack_d;
      dm_ack_o    <= dm_ack_d;
      err_o       <= err_d;
      grant_o     <= grant_d;
`ifdef MEM_ARB_RR_EN
      last_dm_q   <= last_dm_d;
`endif
    end
  end

endmodule
